seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. One BCD/hex-to-segment decoder is shared across all digit positions: each digit gets a fixed slot, and the controller sequences digit enables and decoder input. Digit data enters through a shadow register and is committed only at frame boundaries. The block sits between the counter/arithmetic datapath producing nibble values and the display pins.

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_hex_decode.sv | 9 +
 rtl/seg_scan_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table (a..g in bits 6..0),
// blank glyph and default digit count.
package seg_pkg;

  localparam int unsigned DEFAULT_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost entry; hex glyphs A, b, C, d, E, F occupy 10..15.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit data in / display pins out bundle for seg_scan_ctrl. The master drives the
// scan-run enable, load strobe and nibble data; the slave drives the display outputs.
interface seg_scan_ctrl_if import seg_pkg::*; #(
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) ();

  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     dig_en;
  logic                  frame_done;

  modport master (
    output enable, load, data_in,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  enable, load, data_in,
    output seg, dig_en, frame_done
  );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit nibble to seven-segment glyph decoder (active-high, a..g in bits 6..0).
module seg_hex_decode import seg_pkg::*; (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb glyph = SEG_GLYPHS[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with shadow/active digit registers.
// Define SEG_SCAN_LZB_EN to compile in leading-zero blanking.
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int unsigned DIGITS       = DEFAULT_DIGITS,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = $clog2(DIGITS);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                frame_done_q, frame_done_d;

  logic                last_cnt, boundary, show;
  logic [3:0]          nibble;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   lead_zero;

  assign last_cnt = (cnt_q == CntW'(PRESCALE - 1));
  assign boundary = last_cnt && (idx_q == IdxW'(DIGITS - 1));
  assign nibble   = active_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

`ifdef SEG_SCAN_LZB_EN
  logic zero_above;
  // Scan from the top digit down; digit 0 is never marked.
  always_comb begin
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above & (active_q[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_above;
    end
  end
`else
  assign lead_zero = '0;
`endif

  assign show = (cnt_q >= CntW'(BLANK_CYCLES)) && !lead_zero[idx_q];

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    seg_d        = SEG_BLANK;
    dig_en_d     = '0;
    frame_done_d = 1'b0;

    if (bus.load) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end

    if (bus.enable) begin
      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
      if (last_cnt) begin
        idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      frame_done_d = boundary;
      if (show) begin
        dig_en_d[idx_q] = 1'b1;
        seg_d           = glyph;
      end
      // Commit only on a real frame wrap; a held boundary while disabled is not a wrap.
      if (boundary) begin
        if (bus.load) begin
          active_d = bus.data_in;
        end else if (pending_q) begin
          active_d = shadow_q;
        end
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_en_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_done = frame_done_q;

endmodule
